// File: rtl/gun_heat_controller.sv
// Gun heat controller: firing adds heat on divided ticks, idling sheds it on a free-running cool tick.
// Define GUN_OVERHEAT_LOCK_EN to compile in the LOCKED state with hysteresis lockout.
module gun_heat_controller #(
  parameter int WIDTH          = 8,
  parameter int HEAT_DIV       = 50000000,
  parameter int COOL_DIV       = 100000000,
  parameter int HEAT_STEP      = 1,
  parameter int COOL_STEP      = 1,
  parameter int OVERHEAT_LEVEL = 255,
  parameter int RECOVER_LEVEL  = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shoot,
  output logic             fire,
  output logic [WIDTH-1:0] heat_level,
  output logic             overheated
);

  localparam int HCW = $clog2(HEAT_DIV);
  localparam int CCW = $clog2(COOL_DIV);
  localparam logic [HCW-1:0]   HCNT_RELOAD = HCW'(HEAT_DIV - 1);
  localparam logic [CCW-1:0]   CCNT_RELOAD = CCW'(COOL_DIV - 1);
  localparam logic [WIDTH:0]   HSTEP       = (WIDTH+1)'(HEAT_STEP);
  localparam logic [WIDTH:0]   CSTEP       = (WIDTH+1)'(COOL_STEP);
  localparam logic [WIDTH-1:0] OVH_LVL     = WIDTH'(OVERHEAT_LEVEL);

  if (HEAT_DIV < 2 || COOL_DIV < 2 || RECOVER_LEVEL >= OVERHEAT_LEVEL) begin : g_bad_params
    $error("gun_heat_controller: illegal divider or level parameters");
  end

`ifdef GUN_OVERHEAT_LOCK_EN
  typedef enum logic [1:0] {IDLE, FIRING, LOCKED} state_e;
  localparam logic [WIDTH-1:0] REC_LVL = WIDTH'(RECOVER_LEVEL);
`else
  typedef enum logic [0:0] {IDLE, FIRING} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] heat_q, heat_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic [CCW-1:0]   ccnt_q, ccnt_d;
  logic             fire_q, fire_d;
  logic             heat_tick, cool_tick;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] s;
    s = {1'b0, a} + HSTEP;
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] d;
    d = {1'b0, a} - CSTEP;
    return ({1'b0, a} >= CSTEP) ? d[WIDTH-1:0] : '0;
  endfunction

  assign heat_tick = (state_q == FIRING) && (hcnt_q == '0);
  assign cool_tick = (ccnt_q == '0);

  always_comb begin
    state_d = state_q;
    heat_d  = heat_q;
    hcnt_d  = HCNT_RELOAD;
    ccnt_d  = cool_tick ? CCNT_RELOAD : ccnt_q - 1'b1;
    fire_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cool_tick) heat_d = sat_sub(heat_q);
        if (shoot) state_d = FIRING;
      end
      FIRING: begin
        // Cool ticks landing here are dropped on purpose: a firing gun never sheds heat.
        hcnt_d = heat_tick ? HCNT_RELOAD : hcnt_q - 1'b1;
        if (heat_tick) begin
          heat_d = sat_add(heat_q);
          fire_d = 1'b1;
        end
        if (!shoot) state_d = IDLE;
`ifdef GUN_OVERHEAT_LOCK_EN
        if (heat_tick && (heat_d >= OVH_LVL)) state_d = LOCKED;
`endif
      end
`ifdef GUN_OVERHEAT_LOCK_EN
      LOCKED: begin
        if (cool_tick) heat_d = sat_sub(heat_q);
        if (heat_q <= REC_LVL) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      heat_q  <= '0;
      hcnt_q  <= HCNT_RELOAD;
      ccnt_q  <= CCNT_RELOAD;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      heat_q  <= heat_d;
      hcnt_q  <= hcnt_d;
      ccnt_q  <= ccnt_d;
      fire_q  <= fire_d;
    end
  end

`ifdef GUN_OVERHEAT_LOCK_EN
  assign overheated = (state_q == LOCKED);
`else
  logic ovh_q;

  // Compare against the next heat value so the flag lines up with heat_level.
  always_ff @(posedge clock) begin
    if (reset) ovh_q <= 1'b0;
    else       ovh_q <= (heat_d >= OVH_LVL);
  end

  assign overheated = ovh_q;
`endif

  assign fire       = fire_q;
  assign heat_level = heat_q;

endmodule

// File: tb/tb_gun_heat_controller.sv
// Directed bench for gun_heat_controller (WIDTH=4, HEAT_DIV=4, COOL_DIV=8, OVERHEAT=12, RECOVER=4).
// Works with or without GUN_OVERHEAT_LOCK_EN defined.
module tb_gun_heat_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       shoot = 1'b0;
  logic       fire;
  logic [3:0] heat_level;
  logic       overheated;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gun_heat_controller #(
    .WIDTH(4), .HEAT_DIV(4), .COOL_DIV(8), .HEAT_STEP(1), .COOL_STEP(1),
    .OVERHEAT_LEVEL(12), .RECOVER_LEVEL(4)
  ) dut (
    .clock(clock), .reset(reset), .shoot(shoot),
    .fire(fire), .heat_level(heat_level), .overheated(overheated)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst;
    logic sh;
    int   n;
    logic f;
    int   h;
    logic o;
  } vec_t;

  vec_t vecs[9];

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string tag, input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s %s cycle %0d: got %0d expected %0d", tag, what, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic ef, input int eh,
                      input logic eo, input string tag);
    reset = r;
    shoot = s;
    @(posedge clock);
    #1;
    cyc++;
    chk(tag, "fire", int'(fire), int'(ef));
    chk(tag, "heat_level", int'(heat_level), eh);
    chk(tag, "overheated", int'(overheated), int'(eo));
  endtask

  task automatic run(input int n, input logic r, input logic s, input logic ef,
                     input int eh, input logic eo, input string tag);
    for (int i = 0; i < n; i++) step(r, s, ef, eh, eo, tag);
  endtask

  // Starts from IDLE with heat 0 and shoot held: 4 quiet cycles before the first
  // pulse, then 3 between pulses, heat counting up by one per pulse.
  task automatic ramp(input int kmax, input string tag);
    for (int k = 1; k <= kmax; k++) begin
      int   pre;
      int   hp;
      int   ht;
      logic op;
      logic ot;
      pre = (k == 1) ? 4 : 3;
      hp  = sat(k - 1);
      ht  = sat(k);
`ifdef GUN_OVERHEAT_LOCK_EN
      op = 1'b0;
      ot = (ht >= 12);
`else
      op = (hp >= 12);
      ot = (ht >= 12);
`endif
      run(pre, 1'b0, 1'b1, 1'b0, hp, op, tag);
      step(1'b0, 1'b1, 1'b1, ht, ot, tag);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0,  3, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 10, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b0, 1'b1,  4, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b1,  1, 1'b1, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b1,  3, 1'b0, 1, 1'b0};
    vecs[5] = '{1'b0, 1'b1,  1, 1'b1, 2, 1'b0};
    vecs[6] = '{1'b0, 1'b0,  4, 1'b0, 2, 1'b0};
    vecs[7] = '{1'b0, 1'b0,  8, 1'b0, 1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16, 1'b0, 0, 1'b0};

    for (int v = 0; v < 9; v++)
      run(vecs[v].n, vecs[v].rst, vecs[v].sh, vecs[v].f, vecs[v].h, vecs[v].o,
          $sformatf("vec%0d", v));

`ifdef GUN_OVERHEAT_LOCK_EN
    ramp(12, "lock_ramp");
    run(7, 1'b0, 1'b1, 1'b0, 12, 1'b1, "locked_hold");
    for (int h = 11; h >= 5; h--)
      run(8, 1'b0, 1'b1, 1'b0, h, 1'b1, "locked_cool");
    step(1'b0, 1'b1, 1'b0, 4, 1'b1, "recover_edge");
    run(5, 1'b0, 1'b1, 1'b0, 4, 1'b0, "recovered");
    step(1'b0, 1'b1, 1'b1, 5, 1'b0, "refire");
    run(3, 1'b0, 1'b1, 1'b0, 5, 1'b0, "refire_gap");
    step(1'b0, 1'b1, 1'b1, 6, 1'b0, "refire2");

    step(1'b1, 1'b0, 1'b0, 0, 1'b0, "reset2");
    ramp(12, "lock_ramp2");
    run(6, 1'b0, 1'b1, 1'b0, 12, 1'b1, "locked_hold2");
    run(8, 1'b0, 1'b1, 1'b0, 11, 1'b1, "locked_cool2");
    run(8, 1'b0, 1'b1, 1'b0, 10, 1'b1, "locked_cool2");
    step(1'b0, 1'b1, 1'b0, 9, 1'b1, "locked_at9");
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, "reset_in_locked");
    ramp(2, "restart");
`else
    ramp(20, "sat_ramp");
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, "reset_in_firing");
    ramp(2, "restart");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
